// File: rtl/bullet_sched.sv
// Player bullet scheduler: turns fire presses into bullet spawns (with a
// frame-based cooldown) and moves every active bullet up once per frame by
// sweeping the slots one per cycle after each frame_tick.
//
// state  | meaning
// IDLE   | waiting for frame_tick; pending fire requests are serviced here
// UPDATE | sweeping slots 0..NUM_SLOTS-1, one slot per cycle
module bullet_sched #(
   parameter int NUM_SLOTS = 4,
   parameter int COOLDOWN  = 8,
   parameter int SPEED     = 4,
   parameter int SPAWN_Y   = 432,
   parameter int X_OFS     = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_tick,
   input  logic                    fire,
   input  logic [9:0]              paddle_x,
   input  logic                    hit_valid,
   input  logic [2:0]              hit_slot,
   output logic [NUM_SLOTS-1:0]    bullet_active,
   output logic [10*NUM_SLOTS-1:0] bullet_x,
   output logic [9*NUM_SLOTS-1:0]  bullet_y,
   output logic                    fire_accepted,
   output logic                    fire_dropped,
   output logic                    tick_overrun,
   output logic                    busy
);

   localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

   typedef enum logic {IDLE, UPDATE} state_t;

   state_t         state, state_nxt;
   logic [2:0]     idx, idx_nxt;
   logic           fire_prev;
   logic           pending;
   logic [CW-1:0]  cooldown;

   logic           fire_rise;
   logic           req;
   logic           service;
   logic           spawn;
   logic           free_found;
   logic [2:0]     free_idx;
   logic [NUM_SLOTS-1:0] hit_mask;

   assign busy      = (state == UPDATE);
   assign fire_rise = fire & ~fire_prev;
   assign req       = pending | fire_rise;
   assign service   = (state == IDLE) & req;
   assign spawn     = service & (cooldown == '0) & free_found;

   // Lowest-index inactive slot is the spawn target.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!bullet_active[i]) begin
            free_found = 1'b1;
            free_idx   = 3'(i);
         end
      end
   end

   // Collision clears only act on slots that are currently live; an index
   // past the last slot never matches.
   always_comb begin
      hit_mask = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         hit_mask[i] = hit_valid && (hit_slot == 3'(i)) && bullet_active[i];
      end
   end

   // State and sweep index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state: a frame_tick starts a sweep, the last slot ends it.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            idx_nxt = '0;
            if (frame_tick) state_nxt = UPDATE;
         end
         UPDATE: begin
            if (idx == 3'(NUM_SLOTS - 1)) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + 3'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // Fire request tracking, cooldown down-counter and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fire_prev     <= 1'b0;
         pending       <= 1'b0;
         cooldown      <= '0;
         fire_accepted <= 1'b0;
         fire_dropped  <= 1'b0;
         tick_overrun  <= 1'b0;
      end else begin
         fire_prev     <= fire;
         pending       <= service ? 1'b0 : req;
         fire_accepted <= spawn;
         fire_dropped  <= service & ~spawn;
         tick_overrun  <= frame_tick & (state == UPDATE);
         // A fresh spawn reloads the cooldown even if a tick lands on it.
         if (spawn)
            cooldown <= CW'(COOLDOWN);
         else if (frame_tick && cooldown != '0)
            cooldown <= cooldown - 1'b1;
      end
   end

   // Per-slot state: hit clear wins, then spawn (IDLE only), then movement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bullet_active <= '0;
         bullet_x      <= '0;
         bullet_y      <= '0;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit_mask[i]) begin
               bullet_active[i] <= 1'b0;
            end else if (spawn && free_idx == 3'(i)) begin
               bullet_active[i]  <= 1'b1;
               bullet_x[10*i +: 10] <= paddle_x + 10'(X_OFS);
               bullet_y[9*i +: 9]   <= 9'(SPAWN_Y);
            end else if (state == UPDATE && idx == 3'(i) && bullet_active[i]) begin
               if (bullet_y[9*i +: 9] < 9'(SPEED))
                  bullet_active[i] <= 1'b0;
               else
                  bullet_y[9*i +: 9] <= bullet_y[9*i +: 9] - 9'(SPEED);
            end
         end
      end
   end

endmodule

// File: tb/tb_bullet_sched.sv
// Bench for bullet_sched: directed scenarios followed by random traffic, all
// checked each cycle against a slot-list reference model.
module tb_bullet_sched;

   localparam int NS  = 4;
   localparam int CD  = 8;
   localparam int SPD = 4;
   localparam int SY  = 432;
   localparam int XO  = 14;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              frame_tick = 1'b0;
   logic              fire = 1'b0;
   logic [9:0]        paddle_x = '0;
   logic              hit_valid = 1'b0;
   logic [2:0]        hit_slot = '0;
   logic [NS-1:0]     bullet_active;
   logic [10*NS-1:0]  bullet_x;
   logic [9*NS-1:0]   bullet_y;
   logic              fire_accepted, fire_dropped, tick_overrun, busy;

   int n_cmp = 0;
   int n_bad = 0;

   bullet_sched #(.NUM_SLOTS(NS), .COOLDOWN(CD), .SPEED(SPD), .SPAWN_Y(SY), .X_OFS(XO)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire), .paddle_x(paddle_x),
      .hit_valid(hit_valid), .hit_slot(hit_slot), .bullet_active(bullet_active),
      .bullet_x(bullet_x), .bullet_y(bullet_y), .fire_accepted(fire_accepted),
      .fire_dropped(fire_dropped), .tick_overrun(tick_overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   // reference model
   bit m_act [NS];
   int m_x   [NS];
   int m_y   [NS];
   int m_cd;
   bit m_pend, m_prev;
   int m_sweep;            // slot to be moved this cycle, -1 when no sweep
   bit e_acc, e_drop, e_ovr;

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      m_cd = 0; m_pend = 0; m_prev = 0; m_sweep = -1;
      e_acc = 0; e_drop = 0; e_ovr = 0;
   endtask

   task automatic model_step();
      int fr, h, mv;
      bit sweeping, rise, req, srv, spn;
      if (rst) begin
         model_reset();
         return;
      end
      sweeping = (m_sweep >= 0);
      rise = fire && !m_prev;
      req  = m_pend || rise;
      srv  = !sweeping && req;
      fr = -1;
      for (int i = NS - 1; i >= 0; i--) if (!m_act[i]) fr = i;
      spn = srv && (m_cd == 0) && (fr >= 0);
      e_acc  = spn;
      e_drop = srv && !spn;
      e_ovr  = frame_tick && sweeping;
      h = -1;
      if (hit_valid && int'(hit_slot) < NS) if (m_act[hit_slot]) h = int'(hit_slot);
      mv = sweeping ? m_sweep : -1;
      if (mv >= 0 && mv != h && m_act[mv]) begin
         if (m_y[mv] < SPD) m_act[mv] = 0;
         else m_y[mv] = m_y[mv] - SPD;
      end
      if (spn) begin
         m_act[fr] = 1;
         m_x[fr] = (int'(paddle_x) + XO) % 1024;
         m_y[fr] = SY;
      end
      if (h >= 0) m_act[h] = 0;
      if (spn) m_cd = CD;
      else if (frame_tick && m_cd > 0) m_cd = m_cd - 1;
      m_pend = srv ? 1'b0 : req;
      m_prev = fire;
      if (sweeping) m_sweep = (m_sweep == NS - 1) ? -1 : m_sweep + 1;
      else if (frame_tick) m_sweep = 0;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [NS-1:0]    va;
      logic [10*NS-1:0] vx;
      logic [9*NS-1:0]  vy;
      for (int i = 0; i < NS; i++) begin
         va[i] = m_act[i];
         vx[10*i +: 10] = m_x[i][9:0];
         vy[9*i +: 9]   = m_y[i][8:0];
      end
      check("active", 64'(bullet_active), 64'(va));
      check("x", 64'(bullet_x), 64'(vx));
      check("y", 64'(bullet_y), 64'(vy));
      check("accepted", 64'(fire_accepted), 64'(e_acc));
      check("dropped", 64'(fire_dropped), 64'(e_drop));
      check("overrun", 64'(tick_overrun), 64'(e_ovr));
      check("busy", 64'(busy), 64'(m_sweep >= 0));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   // one frame tick, then count busy cycles over the following window
   task automatic tick_frame(output int nbusy);
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      nbusy = 0;
      repeat (6) begin
         if (busy === 1'b1) nbusy++;
         cyc();
      end
   endtask

   // two-cycle fire press; reports pulses seen right after the edge
   task automatic press(output logic acc, output logic drp);
      fire = 1'b1;
      cyc();
      acc = fire_accepted;
      drp = fire_dropped;
      cyc();
      fire = 1'b0;
      cyc();
   endtask

   initial begin
      int nb;
      logic acc, drp;
      logic [8:0] y_before;
      bit cleared;

      model_reset();
      cyc();
      cyc();
      rst = 1'b0;
      check("rst_active", 64'(bullet_active), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      cyc();

      // first shot
      paddle_x = 10'd300;
      fire = 1'b1;
      cyc();
      check("shot1_acc", 64'(fire_accepted), 64'd1);
      check("shot1_act", 64'(bullet_active), 64'b0001);
      check("shot1_x", 64'(bullet_x[9:0]), 64'd314);
      check("shot1_y", 64'(bullet_y[8:0]), 64'd432);
      cyc();
      fire = 1'b0;
      cyc();

      repeat (2) begin
         tick_frame(nb);
         check("busy_len", 64'(nb), 64'd4);
      end
      press(acc, drp);
      check("cooldown_drop", 64'(drp), 64'd1);
      check("cooldown_noacc", 64'(acc), 64'd0);
      tick_frame(nb);
      check("busy_len3", 64'(nb), 64'd4);
      check("y_after3", 64'(bullet_y[8:0]), 64'd420);

      repeat (5) tick_frame(nb);
      press(acc, drp);
      check("shot2_acc", 64'(acc), 64'd1);
      check("shot2_act", 64'(bullet_active), 64'b0011);
      check("shot2_x", 64'(bullet_x[19:10]), 64'd314);

      repeat (2) begin
         repeat (8) tick_frame(nb);
         press(acc, drp);
         check("fill_acc", 64'(acc), 64'd1);
      end
      check("full", 64'(bullet_active), 64'b1111);
      repeat (8) tick_frame(nb);
      press(acc, drp);
      check("full_drop", 64'(drp), 64'd1);
      check("full_keep", 64'(bullet_active), 64'b1111);

      // run slot0 up to the top until it retires (bounded)
      cleared = 0;
      for (int k = 0; k < 100 && !cleared; k++) begin
         tick_frame(nb);
         if (bullet_active[0] === 1'b0) cleared = 1;
      end
      check("top_clear", 64'(cleared), 64'd1);
      check("top_y_frozen", 64'(bullet_y[8:0]), 64'd0);

      // collision on slot2 in the same cycle as its movement
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
      cyc();
      y_before = bullet_y[26:18];
      hit_valid = 1'b1;
      hit_slot = 3'd2;
      cyc();
      hit_valid = 1'b0;
      check("hit_clear", 64'(bullet_active[2]), 64'd0);
      check("hit_y_hold", 64'(bullet_y[26:18]), 64'(y_before));
      repeat (3) cyc();

      // frame_tick on the second sweep cycle
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      check("overrun_pulse", 64'(tick_overrun), 64'd1);
      repeat (5) cyc();

      // asynchronous reset mid-sweep
      fire = 1'b1;
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
      #2 rst = 1'b1;
      #1;
      check("arst_active", 64'(bullet_active), 64'd0);
      check("arst_x", 64'(bullet_x), 64'd0);
      check("arst_y", 64'(bullet_y), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_pulses", 64'({fire_accepted, fire_dropped, tick_overrun}), 64'd0);
      fire = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 5) == 0) fire = ~fire;
         frame_tick = ($urandom_range(0, 9) == 0);
         hit_valid  = ($urandom_range(0, 7) == 0);
         hit_slot   = 3'($urandom_range(0, 7));
         paddle_x   = 10'($urandom_range(0, 1023));
         rst        = ($urandom_range(0, 999) == 0);
         cyc();
      end
      rst = 1'b0;
      frame_tick = 1'b0;
      hit_valid = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bullet_sched.md
BULLET_SCHED -- requirements
Module: bullet_sched

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of player bullet slots (2..8).
REQ-002 SHALL have parameter COOLDOWN, default 8, frames between accepted shots.
REQ-003 SHALL have parameter SPEED, default 4, pixels moved up per frame.
REQ-004 SHALL have parameter SPAWN_Y, default 432, initial bullet y; parameter X_OFS, default 14, added to paddle_x.
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse, start of vblank.
REQ-008 SHALL have port fire  input  1  synchronized fire button level.
REQ-009 SHALL have port paddle_x  input  10  paddle left x.
REQ-010 SHALL have port hit_valid  input  1  collision report, clears slot hit_slot.
REQ-011 SHALL have port hit_slot  input  3  slot index of collision.
REQ-012 SHALL have port bullet_active  output  NUM_SLOTS  per-slot active flag.
REQ-013 SHALL have port bullet_x  output  10*NUM_SLOTS  packed x, slot i at [10i+9:10i].
REQ-014 SHALL have port bullet_y  output  9*NUM_SLOTS  packed y, slot i at [9i+8:9i].
REQ-015 SHALL have ports fire_accepted, fire_dropped, tick_overrun  output  1 each  one-cycle status pulses.
REQ-016 SHALL have port busy  output  1  high while in UPDATE.

Function
REQ-017 SHALL detect fire rising edge with a registered previous-fire bit; a level held high yields one request.
REQ-018 SHALL hold a one-deep pending request; a rising edge while pending is merged (no extra shot).
REQ-019 SHALL use FSM states IDLE and UPDATE; IDLE->UPDATE on frame_tick, UPDATE->IDLE after slot NUM_SLOTS-1 processed.
REQ-020 SHALL in UPDATE process one slot per cycle in index order 0..NUM_SLOTS-1; frame_tick at cycle N gives slot i updated at end of N+1+i, busy high N+1..N+NUM_SLOTS.
REQ-021 SHALL for an active slot being processed: if y < SPEED, clear active; else y <= y - SPEED (no wrap below 0).
REQ-022 SHALL service a pending request only in IDLE: if cooldown==0 and a free slot exists, activate lowest-index free slot with x=paddle_x+X_OFS (10-bit truncating), y=SPAWN_Y, pulse fire_accepted, load cooldown=COOLDOWN; outputs visible the following cycle.
REQ-023 SHALL, if cooldown!=0 or no slot free when serviced, drop the request and pulse fire_dropped.
REQ-024 SHALL decrement cooldown by 1 on each frame_tick while non-zero, in any state, saturating at 0.
REQ-025 SHALL ignore frame_tick received in UPDATE for movement and pulse tick_overrun.
REQ-026 SHALL on hit_valid with hit_slot<NUM_SLOTS clear that slot active next cycle, with priority over movement and spawn of that slot; out-of-range or inactive-slot hits are ignored.
REQ-027 SHALL when spawn and frame_tick coincide in IDLE, perform spawn and enter UPDATE; the new slot moves in that sweep.
REQ-028 SHALL leave x/y of inactive slots frozen at last values.

Reset
REQ-029 SHALL on rst clear: bullet_active=0, all x=0, y=0, cooldown=0, pending=0, previous-fire=0, state=IDLE, all pulses and busy 0.
REQ-030 SHALL honor rst mid-UPDATE, abandoning the sweep and discarding any pending request.

Verification
REQ-031 Reset, fire pulse 2 cycles, paddle_x=300 -> next cycle fire_accepted=1, slot0 active, x=314, y=432.
REQ-032 After spawn, 3 frame_ticks -> slot0 y=420; busy high exactly 4 cycles per tick.
REQ-033 Second fire edge 2 frames after first -> fire_dropped; after 8 frame_ticks fire -> accepted into slot1.
REQ-034 All 4 slots active, cooldown 0, fire -> fire_dropped, bullet_active stays 4'b1111.
REQ-035 Slot y=2, frame_tick -> slot cleared; hit_valid slot2 same cycle as its update -> cleared, y unchanged.
REQ-036 frame_tick on 2nd cycle of UPDATE -> tick_overrun pulse, no extra movement; rst mid-sweep -> all outputs 0.
